// File: rtl/neuron_sgd_pkg.sv
// Shared types and constants for the RGB neuron SGD trainer.
package neuron_sgd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_UPD   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DERIV_SHIFT = 8;
  localparam int DELTA_SHIFT = 6;
  localparam int W_MAX       = 32767;
  localparam int W_MIN       = -32768;

endpackage

// File: rtl/neuron_sgd_datapath.sv
// Combinational delta-rule math: error, sigmoid derivative, delta and saturating weight steps.
module neuron_sgd_datapath
  import neuron_sgd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 16,
  parameter int LR_SHIFT   = 4
) (
  input  logic        [DATA_WIDTH-1:0] y,
  input  logic        [DATA_WIDTH-1:0] target,
  input  logic        [DATA_WIDTH-1:0] x_r,
  input  logic        [DATA_WIDTH-1:0] x_g,
  input  logic        [DATA_WIDTH-1:0] x_b,
  input  logic signed [DATA_WIDTH:0]   delta_in,
  input  logic        [W_WIDTH-1:0]    w1,
  input  logic        [W_WIDTH-1:0]    w2,
  input  logic        [W_WIDTH-1:0]    w3,
  input  logic        [W_WIDTH-1:0]    bias,
  output logic signed [DATA_WIDTH:0]   err,
  output logic signed [DATA_WIDTH:0]   delta,
  output logic        [W_WIDTH-1:0]    w1_upd,
  output logic        [W_WIDTH-1:0]    w2_upd,
  output logic        [W_WIDTH-1:0]    w3_upd,
  output logic        [W_WIDTH-1:0]    bias_upd
);

  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam int SW = W_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_HI = SW'(W_MAX);
  localparam logic signed [SW-1:0] SAT_LO = SW'(W_MIN);

  // (delta * x) >>> LR_SHIFT with x treated as an unsigned pixel value
  function automatic logic signed [SW-1:0] step_of(input logic signed [DATA_WIDTH:0] d,
                                                    input logic [DATA_WIDTH-1:0] x);
    logic signed [SW-1:0] d_x;
    logic signed [SW-1:0] x_x;
    logic signed [SW-1:0] prod;
    d_x  = {{(SW-DATA_WIDTH-1){d[DATA_WIDTH]}}, d};
    x_x  = {{(SW-DATA_WIDTH){1'b0}}, x};
    prod = d_x * x_x;
    return prod >>> LR_SHIFT;
  endfunction

  function automatic logic [W_WIDTH-1:0] sat_add(input logic [W_WIDTH-1:0] w,
                                                  input logic signed [SW-1:0] step);
    logic signed [SW-1:0] sum;
    sum = $signed({{2{w[W_WIDTH-1]}}, w}) + step;
    if (sum > SAT_HI) begin
      return SAT_HI[W_WIDTH-1:0];
    end else if (sum < SAT_LO) begin
      return SAT_LO[W_WIDTH-1:0];
    end else begin
      return sum[W_WIDTH-1:0];
    end
  endfunction

  logic        [2*DATA_WIDTH-1:0] yy_s;
  logic        [DATA_WIDTH-1:0]   deriv_s;
  logic signed [PW-1:0]           err_x_s;
  logic signed [PW-1:0]           deriv_x_s;
  logic signed [PW-1:0]           prod_s;
  logic signed [PW-1:0]           shifted_s;
  logic signed [SW-1:0]           bias_step_s;

  always_comb begin
    err         = $signed({1'b0, target}) - $signed({1'b0, y});
    // ~y equals 255 - y for an 8-bit value
    yy_s        = {{DATA_WIDTH{1'b0}}, y} * {{DATA_WIDTH{1'b0}}, ~y};
    deriv_s     = yy_s[DERIV_SHIFT +: DATA_WIDTH];
    err_x_s     = {{(PW-DATA_WIDTH-1){err[DATA_WIDTH]}}, err};
    deriv_x_s   = {{(PW-DATA_WIDTH){1'b0}}, deriv_s};
    prod_s      = err_x_s * deriv_x_s;
    shifted_s   = prod_s >>> DELTA_SHIFT;
    delta       = shifted_s[DATA_WIDTH:0];
    bias_step_s = $signed({{(SW-DATA_WIDTH-1){delta_in[DATA_WIDTH]}}, delta_in}) >>> LR_SHIFT;
    w1_upd      = sat_add(w1, step_of(delta_in, x_r));
    w2_upd      = sat_add(w2, step_of(delta_in, x_g));
    w3_upd      = sat_add(w3, step_of(delta_in, x_b));
    bias_upd    = sat_add(bias, bias_step_s);
  end

endmodule

// File: rtl/neuron_sgd_trainer.sv
// Training controller for the RGB neuron: drives a pixel, waits the neuron latency,
// captures the output and applies one saturating delta-rule update to the weights it owns.
module neuron_sgd_trainer
  import neuron_sgd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 16,
  parameter int NEURON_LAT = 3,
  parameter int LR_SHIFT   = 4,
  parameter int W_INIT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_g,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_target,
  input  logic                  train_en,
  input  logic                  cfg_load,
  input  logic [W_WIDTH-1:0]    cfg_w1,
  input  logic [W_WIDTH-1:0]    cfg_w2,
  input  logic [W_WIDTH-1:0]    cfg_w3,
  input  logic [W_WIDTH-1:0]    cfg_bias,
  output logic [DATA_WIDTH-1:0] pix_r,
  output logic [DATA_WIDTH-1:0] pix_g,
  output logic [DATA_WIDTH-1:0] pix_b,
  output logic [W_WIDTH-1:0]    w1,
  output logic [W_WIDTH-1:0]    w2,
  output logic [W_WIDTH-1:0]    w3,
  output logic [W_WIDTH-1:0]    bias,
  input  logic [DATA_WIDTH-1:0] neuron_y,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [DATA_WIDTH:0]   err_out,
  output logic                  upd_done,
  output logic [15:0]           sample_cnt
);

  localparam int CNT_W = $clog2(NEURON_LAT) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NEURON_LAT - 1);
  localparam logic [W_WIDTH-1:0] W_RST    = W_WIDTH'(W_INIT);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]        pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic [DATA_WIDTH-1:0]        target_q, target_d;
  logic                         train_q, train_d;
  logic signed [DATA_WIDTH:0]   delta_q, delta_d;
  logic [W_WIDTH-1:0]           w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, bias_q, bias_d;
  logic [DATA_WIDTH-1:0]        y_out_q, y_out_d;
  logic [DATA_WIDTH:0]          err_out_q, err_out_d;
  logic                         upd_done_q, upd_done_d;
  logic [15:0]                  sample_cnt_q, sample_cnt_d;
  logic                         in_ready_q, in_ready_d;

  logic signed [DATA_WIDTH:0]   err_s, delta_s;
  logic [W_WIDTH-1:0]           w1_upd_s, w2_upd_s, w3_upd_s, bias_upd_s;

  neuron_sgd_datapath #(
    .DATA_WIDTH(DATA_WIDTH),
    .W_WIDTH   (W_WIDTH),
    .LR_SHIFT  (LR_SHIFT)
  ) u_datapath (
    .y        (neuron_y),
    .target   (target_q),
    .x_r      (pix_r_q),
    .x_g      (pix_g_q),
    .x_b      (pix_b_q),
    .delta_in (delta_q),
    .w1       (w1_q),
    .w2       (w2_q),
    .w3       (w3_q),
    .bias     (bias_q),
    .err      (err_s),
    .delta    (delta_s),
    .w1_upd   (w1_upd_s),
    .w2_upd   (w2_upd_s),
    .w3_upd   (w3_upd_s),
    .bias_upd (bias_upd_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pix_r_d      = pix_r_q;
    pix_g_d      = pix_g_q;
    pix_b_d      = pix_b_q;
    target_d     = target_q;
    train_d      = train_q;
    delta_d      = delta_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    bias_d       = bias_q;
    y_out_d      = y_out_q;
    err_out_d    = err_out_q;
    upd_done_d   = 1'b0;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A config load wins over a sample presented in the same cycle
        if (cfg_load) begin
          w1_d   = cfg_w1;
          w2_d   = cfg_w2;
          w3_d   = cfg_w3;
          bias_d = cfg_bias;
        end else if (in_valid) begin
          pix_r_d  = in_r;
          pix_g_d  = in_g;
          pix_b_d  = in_b;
          target_d = in_target;
          train_d  = train_en;
          cnt_d    = '0;
          state_d  = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        y_out_d   = neuron_y;
        err_out_d = err_s;
        delta_d   = delta_s;
        state_d   = ST_UPD;
      end
      ST_UPD: begin
        if (train_q) begin
          w1_d   = w1_upd_s;
          w2_d   = w2_upd_s;
          w3_d   = w3_upd_s;
          bias_d = bias_upd_s;
        end else begin
          w1_d = w1_q;
        end
        // Pulse and count become visible together in DONE
        upd_done_d   = 1'b1;
        sample_cnt_d = sample_cnt_q + 16'd1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE) ? 1'b1 : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      target_q     <= '0;
      train_q      <= 1'b0;
      delta_q      <= '0;
      w1_q         <= W_RST;
      w2_q         <= W_RST;
      w3_q         <= W_RST;
      bias_q       <= W_RST;
      y_out_q      <= '0;
      err_out_q    <= '0;
      upd_done_q   <= 1'b0;
      sample_cnt_q <= 16'd0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      target_q     <= target_d;
      train_q      <= train_d;
      delta_q      <= delta_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      bias_q       <= bias_d;
      y_out_q      <= y_out_d;
      err_out_q    <= err_out_d;
      upd_done_q   <= upd_done_d;
      sample_cnt_q <= sample_cnt_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign pix_r      = pix_r_q;
  assign pix_g      = pix_g_q;
  assign pix_b      = pix_b_q;
  assign w1         = w1_q;
  assign w2         = w2_q;
  assign w3         = w3_q;
  assign bias       = bias_q;
  assign y_out      = y_out_q;
  assign err_out    = err_out_q;
  assign upd_done   = upd_done_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_neuron_sgd_trainer.sv
// Bench for neuron_sgd_trainer: directed and random samples against an arithmetic reference model,
// with the neuron modelled as a 3-deep pipeline returning a bench-chosen output.
module tb_neuron_sgd_trainer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, train_en, cfg_load;
  logic [7:0]  in_r, in_g, in_b, in_target;
  logic [15:0] cfg_w1, cfg_w2, cfg_w3, cfg_bias;
  logic [7:0]  pix_r, pix_g, pix_b, neuron_y, y_out;
  logic [15:0] w1, w2, w3, bias, sample_cnt;
  logic [8:0]  err_out;
  logic        upd_done;

  int checks = 0;
  int errors = 0;

  int m_w [4];
  int m_cnt;

  logic [7:0] y_sel, exp_r, exp_g, exp_b;
  logic [7:0] pipe [3];

  always #5 clk = ~clk;

  neuron_sgd_trainer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_target(in_target),
    .train_en(train_en), .cfg_load(cfg_load),
    .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_w3(cfg_w3), .cfg_bias(cfg_bias),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .w1(w1), .w2(w2), .w3(w3), .bias(bias),
    .neuron_y(neuron_y), .y_out(y_out), .err_out(err_out),
    .upd_done(upd_done), .sample_cnt(sample_cnt)
  );

  // Neuron stand-in: returns y_sel only once the expected pixel has propagated through 3 stages
  always @(posedge clk) begin
    pipe[0] <= (pix_r == exp_r && pix_g == exp_g && pix_b == exp_b) ? y_sel : (y_sel ^ 8'h5A);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign neuron_y = pipe[2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check_weights(input string tag);
    check({tag, "_w1"},   int'($signed(w1)),   m_w[0]);
    check({tag, "_w2"},   int'($signed(w2)),   m_w[1]);
    check({tag, "_w3"},   int'($signed(w3)),   m_w[2]);
    check({tag, "_bias"}, int'($signed(bias)), m_w[3]);
  endtask

  task automatic do_cfg(input int a, input int b, input int c, input int d);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_w1 = 16'(a); cfg_w2 = 16'(b); cfg_w3 = 16'(c); cfg_bias = 16'(d);
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
    m_w[0] = a; m_w[1] = b; m_w[2] = c; m_w[3] = d;
    check_weights("cfg");
  endtask

  // One full sample; noise=1 keeps in_valid/cfg_load asserted with a different pixel while busy
  task automatic do_sample(input string tag, input int r, input int g, input int b, input int tgt,
                           input bit tr, input int y, input bit noise);
    int err, deriv, delta, lat, wait_cnt;
    int x [3];
    bit got;
    x[0] = r; x[1] = g; x[2] = b;
    err   = tgt - y;
    deriv = (y * (255 - y)) / 256;
    delta = (err * deriv) >>> 6;
    if (tr) begin
      for (int i = 0; i < 3; i++) m_w[i] = sat(m_w[i] + ((delta * x[i]) >>> 4));
      m_w[3] = sat(m_w[3] + (delta >>> 4));
    end
    m_cnt = (m_cnt + 1) % 65536;

    @(negedge clk);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({tag, "_ready_before"}, int'(in_ready), 1);
    exp_r = 8'(r); exp_g = 8'(g); exp_b = 8'(b); y_sel = 8'(y);
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b); in_target = 8'(tgt);
    train_en = tr; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (noise) begin
      in_r = ~8'(r); in_target = ~8'(tgt); train_en = ~tr; cfg_load = 1'b1;
      cfg_w1 = 16'h1234; cfg_w2 = 16'h4321; cfg_w3 = 16'h0F0F; cfg_bias = 16'h7777;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (noise && lat == 4) begin
        in_valid = 1'b0;
        cfg_load = 1'b0;
      end
      if (upd_done) got = 1'b1;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_pix_r"}, int'(pix_r), r);
    check({tag, "_y_out"}, int'(y_out), y);
    check({tag, "_err_out"}, int'($signed(err_out)), err);
    check({tag, "_cnt"}, int'(sample_cnt), m_cnt);
    check_weights(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse_low"}, int'(upd_done), 0);
    check({tag, "_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    int ysel;
    rst = 1'b1;
    in_valid = 1'b0; cfg_load = 1'b0; train_en = 1'b0;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; in_target = 8'd0;
    cfg_w1 = 16'd0; cfg_w2 = 16'd0; cfg_w3 = 16'd0; cfg_bias = 16'd0;
    y_sel = 8'd0; exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
    m_w[0] = 0; m_w[1] = 0; m_w[2] = 0; m_w[3] = 0;
    m_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_done", int'(upd_done), 0);
    check("rst_cnt", int'(sample_cnt), 0);
    check("rst_yout", int'(y_out), 0);
    check("rst_err", int'(err_out), 0);
    check("rst_pix", int'(pix_r), 0);
    check_weights("rst");
    rst = 1'b0;

    // Reset arriving mid-DRIVE
    do_cfg(500, -300, 20, 11);
    @(negedge clk);
    in_r = 8'd50; in_g = 8'd60; in_b = 8'd70; in_target = 8'd200; train_en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("drive_busy", int'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_w[0] = 0; m_w[1] = 0; m_w[2] = 0; m_w[3] = 0;
    check("midrst_ready", int'(in_ready), 1);
    check("midrst_cnt", int'(sample_cnt), 0);
    check_weights("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(upd_done), 0);
    end
    check("midrst_cnt_after", int'(sample_cnt), 0);

    // Worked example: delta=125 -> w1=781, bias=7
    do_sample("t2", 100, 0, 0, 255, 1'b1, 128, 1'b0);
    check("t2_w1_lit", int'($signed(w1)), 781);
    check("t2_bias_lit", int'($signed(bias)), 7);
    check("t2_err_lit", int'($signed(err_out)), 127);

    // Inference only
    do_sample("t3", 100, 0, 0, 255, 1'b0, 128, 1'b0);
    check("t3_w1_lit", int'($signed(w1)), 781);

    // Saturation both directions
    do_cfg(32700, 0, 0, 0);
    do_sample("t4p", 255, 0, 0, 255, 1'b1, 128, 1'b0);
    check("t4p_w1_lit", int'($signed(w1)), 32767);
    do_cfg(-32700, 0, 0, 0);
    do_sample("t4n", 255, 0, 0, 0, 1'b1, 128, 1'b0);
    check("t4n_w1_lit", int'($signed(w1)), -32768);

    // Zero derivative at the rails, with busy-time noise on the inputs
    do_cfg(100, -200, 300, -400);
    do_sample("t5a", 10, 20, 30, 0, 1'b1, 255, 1'b1);
    do_sample("t5b", 40, 50, 60, 255, 1'b1, 0, 1'b1);

    // cfg_load and in_valid together in IDLE: load wins
    @(negedge clk);
    cfg_load = 1'b1; in_valid = 1'b1;
    cfg_w1 = 16'd7; cfg_w2 = 16'd8; cfg_w3 = 16'd9; cfg_bias = 16'hFFFE;
    in_r = 8'd99; in_target = 8'd1; train_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    m_w[0] = 7; m_w[1] = 8; m_w[2] = 9; m_w[3] = -2;
    check("t5c_ready", int'(in_ready), 1);
    check_weights("t5c");
    repeat (6) @(negedge clk);
    check("t5c_cnt", int'(sample_cnt), m_cnt);

    // Randomised samples
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       ysel = 0;
        1:       ysel = 255;
        default: ysel = int'($urandom_range(0, 255));
      endcase
      do_sample("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0), ysel, (i % 5 == 0));
    end

    // sample_cnt wrap: preload the counter to 0xFFFF across one idle edge
    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.sample_cnt_q;
    #1;
    m_cnt = 65535;
    check("wrap_preload", int'(sample_cnt), 65535);
    do_sample("wrap", 33, 44, 55, 128, 1'b1, 100, 1'b0);
    check("wrap_zero", int'(sample_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
